// File: rtl/ysyx_23060077_riscv_mem_arbiter_if.sv
// ysyx_23060077_riscv_mem_arbiter_if: IFU/LSU request ports and bridge port of the memory arbiter
// Ports (arbiter view, modport slave):
//  ifu_r_*  IFU read request in, ready/data out
//  lsu_r_*  LSU load request in, ready/data out
//  lsu_w_*  LSU store request/addr/data/strb in, ready out
//  mem_r_*  bridge read: valid/addr out, ready/data in
//  mem_w_*  bridge write: valid/addr/data/strb out, ready in
// modport master is the requester/bridge side.
interface ysyx_23060077_riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_r_valid_i;
  logic [ADDR_W-1:0] ifu_r_addr_i;
  logic              ifu_r_ready_o;
  logic [DATA_W-1:0] ifu_r_data_o;
  logic              lsu_r_valid_i;
  logic [ADDR_W-1:0] lsu_r_addr_i;
  logic              lsu_r_ready_o;
  logic [DATA_W-1:0] lsu_r_data_o;
  logic              lsu_w_valid_i;
  logic [ADDR_W-1:0] lsu_w_addr_i;
  logic [DATA_W-1:0] lsu_w_data_i;
  logic [DATA_W/8-1:0] lsu_w_strb_i;
  logic              lsu_w_ready_o;
  logic              mem_r_valid_o;
  logic [ADDR_W-1:0] mem_r_addr_o;
  logic              mem_r_ready_i;
  logic [DATA_W-1:0] mem_r_data_i;
  logic              mem_w_valid_o;
  logic [ADDR_W-1:0] mem_w_addr_o;
  logic [DATA_W-1:0] mem_w_data_o;
  logic [DATA_W/8-1:0] mem_w_strb_o;
  logic              mem_w_ready_i;
  modport slave (
    input  ifu_r_valid_i, ifu_r_addr_i, lsu_r_valid_i, lsu_r_addr_i,
           lsu_w_valid_i, lsu_w_addr_i, lsu_w_data_i, lsu_w_strb_i,
           mem_r_ready_i, mem_r_data_i, mem_w_ready_i,
    output ifu_r_ready_o, ifu_r_data_o, lsu_r_ready_o, lsu_r_data_o, lsu_w_ready_o,
           mem_r_valid_o, mem_r_addr_o, mem_w_valid_o, mem_w_addr_o, mem_w_data_o, mem_w_strb_o
  );
  modport master (
    output ifu_r_valid_i, ifu_r_addr_i, lsu_r_valid_i, lsu_r_addr_i,
           lsu_w_valid_i, lsu_w_addr_i, lsu_w_data_i, lsu_w_strb_i,
           mem_r_ready_i, mem_r_data_i, mem_w_ready_i,
    input  ifu_r_ready_o, ifu_r_data_o, lsu_r_ready_o, lsu_r_data_o, lsu_w_ready_o,
           mem_r_valid_o, mem_r_addr_o, mem_w_valid_o, mem_w_addr_o, mem_w_data_o, mem_w_strb_o
  );
endinterface

// File: rtl/ysyx_23060077_riscv_mem_arbiter.sv
// ysyx_23060077_riscv_mem_arbiter: shares one AXI-lite bridge between IFU reads and LSU reads/writes
// Ports:
//  clk, rst       clock, synchronous active-high reset
//  bus            request/bridge signals (interface, slave view)
//  grant_o        owner: 0 none, 1 IFU rd, 2 LSU rd, 3 LSU wr
//  timeout_err_o  1-cycle pulse when the watchdog aborts a grant
module ysyx_23060077_riscv_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  ysyx_23060077_riscv_mem_arbiter_if.slave bus,
  output logic [1:0] grant_o,
  output logic timeout_err_o
);
  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;
  logic [7:0] cnt_q, cnt_d;
  logic idle, rd, wr, r_ok, w_ok, to;
  always_comb begin
    idle = state_q == IDLE;
    rd = state_q == IFU_RD || state_q == LSU_RD;
    wr = state_q == LSU_WR;
    // bridge readies only count when they match the granted direction
    r_ok = rd && bus.mem_r_ready_i;
    w_ok = wr && bus.mem_w_ready_i;
    to = TIMEOUT != 0 && !idle && cnt_q == 8'(TIMEOUT) && !r_ok && !w_ok;
    state_d = idle ? (bus.lsu_w_valid_i ? LSU_WR : bus.lsu_r_valid_i ? LSU_RD :
                      bus.ifu_r_valid_i ? IFU_RD : IDLE)
                   : (r_ok || w_ok || to) ? IDLE : state_q;
    cnt_d = idle ? 8'd0 : cnt_q + 8'd1;
    addr_d = !idle ? addr_q : bus.lsu_w_valid_i ? bus.lsu_w_addr_i :
             bus.lsu_r_valid_i ? bus.lsu_r_addr_i : bus.ifu_r_valid_i ? bus.ifu_r_addr_i : addr_q;
    wdata_d = idle && bus.lsu_w_valid_i ? bus.lsu_w_data_i : wdata_q;
    strb_d = idle && bus.lsu_w_valid_i ? bus.lsu_w_strb_i : strb_q;
    bus.mem_r_valid_o = rd && !to;
    bus.mem_w_valid_o = wr && !to;
    bus.mem_r_addr_o = addr_q;
    bus.mem_w_addr_o = addr_q;
    bus.mem_w_data_o = wdata_q;
    bus.mem_w_strb_o = strb_q;
    // an aborted grant still hands its owner a ready, with zero data
    bus.ifu_r_ready_o = state_q == IFU_RD && (r_ok || to);
    bus.lsu_r_ready_o = state_q == LSU_RD && (r_ok || to);
    bus.lsu_w_ready_o = wr && (w_ok || to);
    bus.ifu_r_data_o = state_q == IFU_RD && r_ok ? bus.mem_r_data_i : '0;
    bus.lsu_r_data_o = state_q == LSU_RD && r_ok ? bus.mem_r_data_i : '0;
    grant_o = state_q;
    timeout_err_o = to;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      strb_q <= strb_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ysyx_23060077_riscv_mem_arbiter.sv
// tb_ysyx_23060077_riscv_mem_arbiter: directed self-checking bench for the memory arbiter
module tb_ysyx_23060077_riscv_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] grant;
  logic to_err;
  int n_chk = 0;
  int n_fail = 0;
  ysyx_23060077_riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  ysyx_23060077_riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_o(grant), .timeout_err_o(to_err)
  );
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  initial begin
    bus.ifu_r_valid_i = 0; bus.ifu_r_addr_i = 0;
    bus.lsu_r_valid_i = 0; bus.lsu_r_addr_i = 0;
    bus.lsu_w_valid_i = 0; bus.lsu_w_addr_i = 0; bus.lsu_w_data_i = 0; bus.lsu_w_strb_i = 0;
    bus.mem_r_ready_i = 0; bus.mem_r_data_i = 0; bus.mem_w_ready_i = 0;
    repeat (2) cyc;
    chk("rst_grant", grant, 2'd0);
    chk("rst_rvalid", bus.mem_r_valid_o, 1'b0);
    chk("rst_wvalid", bus.mem_w_valid_o, 1'b0);
    chk("rst_addr", bus.mem_r_addr_o, 32'h0);
    chk("rst_to", to_err, 1'b0);
    rst = 0;
    bus.ifu_r_valid_i = 1; bus.ifu_r_addr_i = 32'h8000_0000;
    cyc;
    chk("t1_grant", grant, 2'd1);
    chk("t1_rvalid", bus.mem_r_valid_o, 1'b1);
    chk("t1_addr", bus.mem_r_addr_o, 32'h8000_0000);
    chk("t1_wvalid", bus.mem_w_valid_o, 1'b0);
    cyc;
    chk("t1_noready", bus.ifu_r_ready_o, 1'b0);
    cyc;
    cyc;
    bus.mem_r_ready_i = 1; bus.mem_r_data_i = 32'h0000_0413;
    #1;
    chk("t1_ready", bus.ifu_r_ready_o, 1'b1);
    chk("t1_data", bus.ifu_r_data_o, 32'h0000_0413);
    chk("t1_lsur", bus.lsu_r_ready_o, 1'b0);
    chk("t1_lsuw", bus.lsu_w_ready_o, 1'b0);
    cyc;
    bus.mem_r_ready_i = 0; bus.ifu_r_valid_i = 0;
    #1;
    chk("t1_idle", grant, 2'd0);
    chk("t1_pulse_end", bus.ifu_r_ready_o, 1'b0);
    bus.ifu_r_valid_i = 1; bus.ifu_r_addr_i = 32'h8000_0004;
    bus.lsu_r_valid_i = 1; bus.lsu_r_addr_i = 32'hA000_0000;
    cyc;
    chk("t2_grant_lsu", grant, 2'd2);
    chk("t2_addr_lsu", bus.mem_r_addr_o, 32'hA000_0000);
    bus.mem_r_ready_i = 1; bus.mem_r_data_i = 32'h0000_1234;
    #1;
    chk("t2_lsu_ready", bus.lsu_r_ready_o, 1'b1);
    chk("t2_lsu_data", bus.lsu_r_data_o, 32'h0000_1234);
    chk("t2_ifu_quiet", bus.ifu_r_ready_o, 1'b0);
    cyc;
    bus.mem_r_ready_i = 0; bus.lsu_r_valid_i = 0;
    #1;
    chk("t2_bubble", grant, 2'd0);
    cyc;
    chk("t2_grant_ifu", grant, 2'd1);
    chk("t2_addr_ifu", bus.mem_r_addr_o, 32'h8000_0004);
    bus.mem_r_ready_i = 1; bus.mem_r_data_i = 32'h0000_0005;
    #1;
    chk("t2_ifu_ready", bus.ifu_r_ready_o, 1'b1);
    cyc;
    bus.mem_r_ready_i = 0; bus.ifu_r_valid_i = 0;
    #1;
    bus.lsu_w_valid_i = 1; bus.lsu_w_addr_i = 32'h8000_0100;
    bus.lsu_w_data_i = 32'hDEAD_BEEF; bus.lsu_w_strb_i = 4'b0011;
    cyc;
    chk("t3_grant", grant, 2'd3);
    chk("t3_wvalid", bus.mem_w_valid_o, 1'b1);
    chk("t3_waddr", bus.mem_w_addr_o, 32'h8000_0100);
    chk("t3_wdata", bus.mem_w_data_o, 32'hDEAD_BEEF);
    chk("t3_wstrb", bus.mem_w_strb_o, 4'b0011);
    chk("t3_rvalid", bus.mem_r_valid_o, 1'b0);
    cyc;
    chk("t3_noready", bus.lsu_w_ready_o, 1'b0);
    bus.mem_w_ready_i = 1;
    #1;
    chk("t3_ready", bus.lsu_w_ready_o, 1'b1);
    cyc;
    bus.mem_w_ready_i = 0; bus.lsu_w_valid_i = 0;
    #1;
    chk("t3_idle", grant, 2'd0);
    bus.ifu_r_valid_i = 1; bus.ifu_r_addr_i = 32'h8000_0008;
    cyc;
    chk("t4_grant", grant, 2'd1);
    for (int k = 1; k < 8; k++) begin
      cyc;
      chk("t4_wait_to", to_err, 1'b0);
      chk("t4_wait_valid", bus.mem_r_valid_o, 1'b1);
    end
    cyc;
    chk("t4_to", to_err, 1'b1);
    chk("t4_ready", bus.ifu_r_ready_o, 1'b1);
    chk("t4_data", bus.ifu_r_data_o, 32'h0);
    chk("t4_rvalid", bus.mem_r_valid_o, 1'b0);
    bus.ifu_r_valid_i = 0;
    cyc;
    chk("t4_idle", grant, 2'd0);
    chk("t4_to_end", to_err, 1'b0);
    bus.lsu_r_valid_i = 1; bus.lsu_r_addr_i = 32'hA000_0010;
    cyc;
    cyc;
    chk("t5_grant", grant, 2'd2);
    rst = 1;
    cyc;
    chk("t5_grant_rst", grant, 2'd0);
    chk("t5_rvalid", bus.mem_r_valid_o, 1'b0);
    chk("t5_addr", bus.mem_r_addr_o, 32'h0);
    chk("t5_lsur", bus.lsu_r_ready_o, 1'b0);
    chk("t5_to", to_err, 1'b0);
    rst = 0; bus.lsu_r_valid_i = 0;
    bus.ifu_r_valid_i = 1; bus.ifu_r_addr_i = 32'h8000_0010;
    cyc;
    chk("t5_regrant", grant, 2'd1);
    chk("t5_readdr", bus.mem_r_addr_o, 32'h8000_0010);
    bus.mem_r_ready_i = 1; bus.mem_r_data_i = 32'h0000_0077;
    #1;
    chk("t5_ready", bus.ifu_r_ready_o, 1'b1);
    cyc;
    bus.mem_r_ready_i = 0; bus.ifu_r_valid_i = 0;
    #1;
    bus.ifu_r_valid_i = 1; bus.ifu_r_addr_i = 32'h8000_0020;
    cyc;
    bus.mem_w_ready_i = 1;
    #1;
    chk("t6_ifu_quiet", bus.ifu_r_ready_o, 1'b0);
    chk("t6_lsuw_quiet", bus.lsu_w_ready_o, 1'b0);
    chk("t6_lsur_quiet", bus.lsu_r_ready_o, 1'b0);
    cyc;
    bus.mem_w_ready_i = 0;
    #1;
    chk("t6_still_grant", grant, 2'd1);
    bus.mem_r_ready_i = 1; bus.mem_r_data_i = 32'h0000_CAFE;
    #1;
    chk("t6_ready", bus.ifu_r_ready_o, 1'b1);
    chk("t6_data", bus.ifu_r_data_o, 32'h0000_CAFE);
    cyc;
    bus.mem_r_ready_i = 0; bus.ifu_r_valid_i = 0;
    #1;
    chk("t6_idle", grant, 2'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
